// File: rtl/div4b_seq.sv
// Sequential unsigned restoring divider: one trial-subtract/shift step per clock,
// start/busy/done handshake, divide-by-zero flagged with Q=all ones and R=A.
module div4b_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] Q,
  output logic [W-1:0] R
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           dz_q, dz_d;

  logic [W-1:0]   rem_sh;
  logic [W:0]     diff;
  logic           launch;

  // Extra top bit makes the borrow of the trial subtraction explicit
  assign rem_sh = {rem_q[W-2:0], dvd_q[W-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: launch = start;
      S_RUN: begin
        // W shift steps, then one more edge to publish the result
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          q_d     = quo_q;
          r_d     = rem_q;
          dz_d    = 1'b0;
        end else begin
          rem_d = diff[W] ? rem_sh : diff[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b0};
          quo_d = {quo_q[W-2:0], ~diff[W]};
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ZERO: begin
        // Two busy cycles keep the zero path aligned with the publish edge of RUN
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          q_d     = '1;
          r_d     = dvd_q;
          dz_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        launch  = start;
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      rem_d   = '0;
      dvd_d   = A;
      dvs_d   = B;
      quo_d   = '0;
      cnt_d   = '0;
      state_d = (B == '0) ? S_ZERO : S_RUN;
    end
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_ZERO);
    done = (state_q == S_DONE);
    dz   = dz_q;
    Q    = q_q;
    R    = r_q;
  end

endmodule

// File: tb/tb_div4b_seq.sv
// Randomized and directed checks of div4b_seq against plain integer division,
// including latency, handshake, divide-by-zero and reset-abort behaviour.
module tb_div4b_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic         busy, done, dz;
  logic [W-1:0] Q, R;

  int checks = 0;
  int failures = 0;

  // Last completed result as the outside world should see it
  int pq = 0, pr = 0, pdz = 0;

  div4b_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .dz(dz), .Q(Q), .R(R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Present operands with start for exactly one rising edge, then scramble inputs
  task automatic launch_now(input int a, input int b);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic launch(input int a, input int b);
    @(negedge clk);
    launch_now(a, b);
  endtask

  // Wait for done; i counts negedges after the accept edge (i=1 is the cycle after it).
  // poke_at>0 pulses a start with A=1,B=1 at that cycle, which must be ignored.
  task automatic finish_op(input int a, input int b, input int poke_at);
    int  exp_n = (b == 0) ? 3 : W + 2;
    int  n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (poke_at > 0 && i == poke_at + 1) start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
      chk("busy_run", busy, 1);
      chk("Q_hold", Q, pq);
      chk("R_hold", R, pr);
      chk("dz_hold", dz, pdz);
      if (poke_at > 0 && i == poke_at) begin
        A = 1;
        B = 1;
        start = 1'b1;
      end
    end
    chk($sformatf("lat_%0d_%0d", a, b), n, exp_n);
    chk($sformatf("Q_%0d_%0d", a, b), Q, ref_q(a, b));
    chk($sformatf("R_%0d_%0d", a, b), R, ref_r(a, b));
    chk($sformatf("dz_%0d_%0d", a, b), dz, (b == 0));
    chk("busy_done", busy, 0);
    if (b != 0) begin
      chk("inv_qbr", 32'(Q) * 32'(b) + 32'(R), a);
      chk("inv_rltb", (R < W'(b)), 1);
    end
    pq = ref_q(a, b);
    pr = ref_r(a, b);
    pdz = (b == 0);
  endtask

  task automatic idle_check(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int ra, rb;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    rst = 1'b0;

    launch(13, 4);  finish_op(13, 4, 0);  idle_check(1);
    launch(15, 1);  finish_op(15, 1, 0);  idle_check(1);
    launch(3, 7);   finish_op(3, 7, 0);   idle_check(1);
    launch(0, 9);   finish_op(0, 9, 0);   idle_check(1);
    launch(5, 0);   finish_op(5, 0, 0);   idle_check(1);
    launch(9, 3);   finish_op(9, 3, 0);   idle_check(1);

    // Ignored mid-run start, then back-to-back relaunch from the done cycle
    launch(14, 3);  finish_op(14, 3, 2);
    launch_now(8, 2);
    finish_op(8, 2, 0);
    idle_check(3);

    // Abort with reset sampled at edge 2 of the op
    launch(12, 5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_Q", Q, 0);
    chk("abort_R", R, 0);
    chk("abort_dz", dz, 0);
    pq = 0; pr = 0; pdz = 0;
    idle_check(8);

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        launch(a, b);
        finish_op(a, b, 0);
      end

    // Random back-to-back chains mixing in divide-by-zero
    @(negedge clk);
    ra = $urandom_range(15); rb = $urandom_range(15);
    launch_now(ra, rb);
    finish_op(ra, rb, 0);
    for (int k = 0; k < 40; k++) begin
      ra = $urandom_range(15);
      rb = ($urandom_range(3) == 0) ? 0 : $urandom_range(15);
      launch_now(ra, rb);
      finish_op(ra, rb, 0);
    end
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
